// File: rtl/timer_arbiter_if.sv
// Request/response bus between a bus master and the timer slave.
// The master side drives the request; the slave side answers.
interface timer_arbiter_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic        valid;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    modport master (
        output address, wdata, wsel, valid,
        input  rdata, ready, error
    );

    modport slave (
        input  address, wdata, wsel, valid,
        output rdata, ready, error
    );
endinterface

// File: rtl/timer_arbiter.sv
// Two-master round-robin arbiter in front of a single timer slave,
// with a per-transaction BUSY timeout.
module timer_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    timer_arbiter_if.slave   m0,
    timer_arbiter_if.slave   m1,
    timer_arbiter_if.master  s
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic          grant;
    logic          last_grant;
    logic [CW-1:0] cnt;

    logic busy;
    logic g_valid;
    logic live;
    logic tmo;
    logic g_ready;
    logic g_error;

    assign busy    = (state == BUSY);
    assign g_valid = grant ? m1.valid : m0.valid;
    assign live    = busy & g_valid;

    // A real slave response always wins over the timeout.
    assign tmo = (TIMEOUT > 0) && (cnt == TMAX)
               && !s.ready && !s.error;

    assign g_ready = live & s.ready;
    assign g_error = live & (s.error | tmo);

    assign s.valid   = busy;
    assign s.address = busy ? (grant ? m1.address : m0.address) : '0;
    assign s.wdata   = busy ? (grant ? m1.wdata : m0.wdata) : '0;
    assign s.wsel    = busy ? (grant ? m1.wsel : m0.wsel) : '0;

    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.ready = g_ready & ~grant;
    assign m1.ready = g_ready & grant;
    assign m0.error = g_error & ~grant;
    assign m1.error = g_error & grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0.valid | m1.valid) begin
                        state <= BUSY;
                        cnt   <= '0;
                        grant <= (m0.valid & m1.valid) ? ~last_grant
                                                       : m1.valid;
                    end
                end
                BUSY: begin
                    // Abort leaves the fairness history untouched.
                    if (!g_valid) begin
                        state <= IDLE;
                    end else if (g_ready | g_error) begin
                        state      <= IDLE;
                        last_grant <= grant;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
